// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM between NUM_REQ draw layers.
// Optional per-requester wait statistics are built when SPRITE_ARB_WAIT_CNT_EN is defined.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [7:0]                max_wait
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a requester raises req[i] with a stable address and holds both until
    // it sees the registered gnt[i] pulse; it may withdraw req[i] earlier, and may
    // re-raise it in the cycle after gnt[i]. The read returns later as rvalid[i].
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               win_vld;
    logic [NUM_REQ-1:0] tag_q [ROM_LAT];

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && req[(int'(ptr) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            gnt      <= '0;
            rom_addr <= '0;
        end else begin
            gnt <= win_vld ? (NUM_REQ'(1) << win_idx) : '0;
            if (win_vld) begin
                rom_addr <= addr[int'(win_idx)*ADDR_W +: ADDR_W];
            end
            // A frame boundary restarts the rotation even if a grant is issued now.
            if (frame_start) begin
                ptr <= '0;
            end else if (win_vld) begin
                ptr <= ptr_nxt;
            end
        end
    end

    // The grant tag follows the ROM read so the data is steered back to its owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
            rdata  <= '0;
            rvalid <= '0;
        end else begin
            tag_q[0] <= gnt;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rvalid <= tag_q[ROM_LAT-1];
            if (|tag_q[ROM_LAT-1]) begin
                rdata <= rom_data;
            end
        end
    end

`ifdef SPRITE_ARB_WAIT_CNT_EN
    logic [7:0] wait_cnt [NUM_REQ];
    logic [7:0] wait_nxt [NUM_REQ];
    logic [7:0] max_nxt;

    always_comb begin
        max_nxt = max_wait;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !(win_vld && (int'(win_idx) == i))) begin
                wait_nxt[i] = (wait_cnt[i] == 8'hFF) ? 8'hFF : wait_cnt[i] + 8'd1;
            end else begin
                wait_nxt[i] = '0;
            end
            if (wait_nxt[i] > max_nxt) begin
                max_nxt = wait_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            max_wait <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= wait_nxt[i];
            end
            max_wait <= frame_start ? 8'd0 : max_nxt;
        end
    end
`else
    assign max_wait = '0;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: grant order, ptr handling, read return and reset.
// Read returns are matched against a scoreboard queue filled when each grant is checked.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 12;
    localparam int SB_W    = NUM_REQ + DATA_W;

`ifdef SPRITE_ARB_WAIT_CNT_EN
    localparam logic [7:0] EXP_MAX_WAIT = 8'd3;
`else
    localparam logic [7:0] EXP_MAX_WAIT = 8'd0;
`endif

    logic                      clk;
    logic                      rst;
    logic                      frame_start;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        rvalid;
    logic [7:0]                max_wait;

    logic [ADDR_W-1:0] addr_v [NUM_REQ];
    logic [SB_W-1:0]   exp_q[$];
    int                n_checks = 0;
    int                n_err    = 0;

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ROM_LAT(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .req        (req),
        .addr       (addr),
        .gnt        (gnt),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .max_wait   (max_wait)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    always_comb begin
        addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr[i*ADDR_W +: ADDR_W] = addr_v[i];
        end
    end

    function automatic logic [DATA_W-1:0] rom_fn(logic [ADDR_W-1:0] a);
        if (a == 10'h05A) return 12'hABC;
        return {2'b01, a} ^ 12'h3C5;
    endfunction

    // Single-port sprite ROM with one cycle of read latency
    always @(posedge clk) begin
        rom_data <= rom_fn(rom_addr);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(int i);
        logic [NUM_REQ-1:0] oh;
        oh = NUM_REQ'(1) << i;
        check($sformatf("gnt_%0d", i), 32'(gnt), 32'(oh));
        check($sformatf("rom_addr_%0d", i), 32'(rom_addr), 32'(addr_v[i]));
        exp_q.push_back({oh, rom_fn(addr_v[i])});
    endtask

    // Scoreboard: every returned read must match the oldest outstanding grant
    always @(negedge clk) begin
        if (rst && (rvalid !== '0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                logic [SB_W-1:0] e;
                e = exp_q.pop_front();
                check("rvalid", 32'(rvalid), 32'(e[SB_W-1:DATA_W]));
                check("rdata", 32'(rdata), 32'(e[DATA_W-1:0]));
            end
        end
    end

    initial begin
        rst         = 1'b0;
        frame_start = 1'b0;
        req         = '0;
        for (int i = 0; i < NUM_REQ; i++) addr_v[i] = '0;
        step();
        step();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_max_wait", 32'(max_wait), 32'd0);
        rst = 1'b1;
        step();

        // Single request from requester 0
        addr_v[0] = 10'h05A;
        req = 4'b0001;
        step();
        expect_grant(0);
        req = 4'b0000;
        step();
        step();
        step();
        check("drain_single", 32'(exp_q.size()), 32'd0);

        // Restart rotation, then all four requesting continuously
        for (int i = 0; i < NUM_REQ; i++) addr_v[i] = 10'($urandom_range(0, 1023));
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            expect_grant(k % NUM_REQ);
        end
        req = 4'b0000;

        // ptr=2 after granting requester 1: 3 then 0
        req = 4'b1001;
        step();
        expect_grant(3);
        req = 4'b0001;
        step();
        expect_grant(0);
        req = 4'b0000;

        // Bring ptr to 3, then frame_start together with a full request
        req = 4'b0100;
        step();
        expect_grant(2);
        req = 4'b1111;
        frame_start = 1'b1;
        step();
        expect_grant(3);
        frame_start = 1'b0;
        step();
        expect_grant(0);
        req = 4'b0000;

        // Requester 0 loses, then withdraws: no grant, rom_addr holds
        req = 4'b0011;
        step();
        expect_grant(1);
        req = 4'b0000;
        step();
        check("idle_gnt", 32'(gnt), 32'd0);
        check("idle_rom_addr_hold", 32'(rom_addr), 32'(addr_v[1]));
        step();
        step();
        step();
        check("drain_main", 32'(exp_q.size()), 32'd0);

        // Reset with two reads in flight; those reads must never return
        req = 4'b0011;
        step();
        check("pre_rst_gnt0", 32'(gnt), 32'b0001);
        req = 4'b0010;
        step();
        check("pre_rst_gnt1", 32'(gnt), 32'b0010);
        req = 4'b0000;
        rst = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_max_wait", 32'(max_wait), 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_rst_rvalid", 32'(rvalid), 32'd0);
        end

        // Twelve cycles of full contention, then a frame boundary
        req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            step();
            expect_grant(k % NUM_REQ);
        end
        check("max_wait_contention", 32'(max_wait), 32'(EXP_MAX_WAIT));
        frame_start = 1'b1;
        step();
        expect_grant(0);
        check("max_wait_frame_clear", 32'(max_wait), 32'd0);
        frame_start = 1'b0;
        req = 4'b0000;
        for (int k = 0; k < 4; k++) step();
        check("drain_final", 32'(exp_q.size()), 32'd0);

        // Final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
